regfile_sb: RTL
===============

# regfile_sb

Parametrised integer register file with a configurable number of registered read ports, write-to-read bypass and a per-register pending-write scoreboard. It sits between decode and execute in the RV32 pipeline.
- Decode reads operands and marks the destination register pending at issue.
- Writeback writes results and clears the pending flag.
- The block flags read-after-write hazards so the hazard unit can stall without its own register tracking.

## Interface
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers; register 0 is hardwired zero
- AW, $clog2(NREG), register address width
- NRD, 2, number of read ports
- BYPASS, 1, 1 = same-cycle writeback is forwarded to reads; 0 = reads return the pre-write value

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (clears state when rst==0 at a rising edge)
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  read addresses; port p uses bits [p*AW +: AW]
- rd_data  out  NRD*XLEN  registered read data; port p uses bits [p*XLEN +: XLEN]
- rd_busy  out  NRD  registered: source was pending and not resolved by the current writeback
- hazard  out  1  combinational OR over enabled ports of the unregistered busy term
- iss_en  in  1  mark register iss_rd pending
- iss_rd  in  AW  destination register being issued
- wb_en  in  1  write enable
- wb_reg  in  AW  write address
- wb_val  in  XLEN  write data
- pend  out  NREG  current pending vector; bit 0 is always 0

## Operation
- **Storage:** NREG-1 flops of XLEN bits. Register 0 is not stored and always reads 0. Writes and issues to register 0 are ignored.
- **Write:** when wb_en=1 and wb_reg≠0, mem[wb_reg] ← wb_val at the edge. pend[wb_reg] clears unless iss_en=1 and iss_rd=wb_reg in the same cycle (new producer wins; pend stays 1).
- **Issue:** when iss_en=1 and iss_rd≠0, pend[iss_rd] sets at the edge.
- **Read, rd_en[p]=1:** at the edge, rd_data[p] loads:
  - 0 if rd_addr[p]=0;
  - else wb_val if BYPASS=1, wb_en=1 and wb_reg=rd_addr[p];
  - else mem[rd_addr[p]].
- **Busy term, port p:** rd_en[p] & pend[rd_addr[p]] & ~(wb_en & wb_reg=rd_addr[p] & BYPASS). It is registered into rd_busy[p].
- **Port idle:** when rd_en[p]=0, rd_data[p] and rd_busy[p] hold their previous values.
- **Multiple ports:** ports are independent. Several ports may read the same address in one cycle and each returns the same value.
- **Out-of-range addresses** (address ≥ NREG, only possible when NREG is not a power of 2): reads return 0, writes and issues are ignored.

## Timing
- **Reset** (rst=0 at an edge): every mem entry, pend, rd_data and rd_busy go to 0. Reset overrides any wb_en, iss_en or rd_en in that cycle.
- **Read latency:** 1 cycle, from rd_en/rd_addr sampled at edge N to rd_data valid after edge N.
- **Write visibility:**
  - BYPASS=1: a write is visible to a read sampled at the same edge.
  - BYPASS=0: a write is visible to reads sampled at the following edge onward.
- **Pending flags:** a pend bit set at edge N is visible in pend and hazard from edge N onward. The hazard output is combinational, in the same cycle as the read request.
- There are no handshakes. Every enabled request is accepted every cycle.

## Structure
- Shared package `rv32_pkg` holds XLEN, NREG, AW and the reg-index zero constant, so decode and hazard logic share them.
- One sub-module, `regfile_rdport`: a single read port containing the address mux, bypass compare, busy term and output flops. It is instantiated NRD times via generate.
- Storage, scoreboard and write logic live in the top module.

## Test plan
- **Reset clear:** write 0xDEADBEEF to x5, then assert rst=0 for one edge, then read x5 → rd_data=0, pend=0, rd_busy=0.
- **x0:** wb_en with wb_reg=0 and wb_val=0xFFFFFFFF, plus iss_rd=0 → a read of x0 returns 0 and pend[0] stays 0.
- **Bypass, BYPASS=1:** x7=0x11 already; same cycle wb x7=0x22 and read x7 on both ports → both rd_data=0x22 the next cycle.
  - With BYPASS=0, the same stimulus returns 0x11, and 0x22 one cycle later.
- **Scoreboard:**
  - Issue x3 at cycle 0, read x3 at cycle 1 → hazard=1, rd_busy=1.
  - wb x3=0x55 at cycle 4 while reading x3 → hazard=0, rd_data=0x55, pend[3]=0.
- **Simultaneous issue and writeback:** iss_rd=wb_reg=9 in one cycle → mem[9] updated, pend[9] remains 1.
- **Port independence with NRD=3:** read x1, x2, x1 with x1=0xA and x2=0xB → 0xA, 0xB, 0xA.
  - Then drop rd_en[1] and change rd_addr[1] → port 1 output holds 0xB.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared register-file geometry for decode, hazard and regfile.
// Keeps XLEN/NREG/AW in one place so every stage agrees on widths.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one registered read port with writeback bypass
// and scoreboard busy term.
module regfile_rdport
    import rv32_pkg::*;
#(
    parameter int XLEN   = rv32_pkg::XLEN,
    parameter int NREG   = rv32_pkg::NREG,
    parameter int AW     = rv32_pkg::AW,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en_i,
    input  logic [AW-1:0]            rd_addr_i,
    input  logic                     wb_en_i,
    input  logic [AW-1:0]            wb_reg_i,
    input  logic [XLEN-1:0]          wb_val_i,
    input  logic [(NREG-1)*XLEN-1:0] mem_i,
    input  logic [NREG-1:1]          pend_i,
    output logic [XLEN-1:0]          rd_data_o,
    output logic                     rd_busy_o,
    output logic                     busy_o
);

    logic [XLEN-1:0] src_val;
    logic            src_pend;
    logic            fwd;
    logic [XLEN-1:0] data_d, data_q;
    logic            busy_d, busy_q;

    // Select stored value and pending flag; x0 and out-of-range give 0.
    always_comb begin
        src_val  = '0;
        src_pend = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (int'(rd_addr_i) == i) begin
                src_val  = mem_i[(i-1)*XLEN +: XLEN];
                src_pend = pend_i[i];
            end
        end
    end

    // Forward same-cycle writeback and form the unregistered busy term.
    always_comb begin
        fwd    = (BYPASS != 0) && wb_en_i
                 && (wb_reg_i == rd_addr_i)
                 && (rd_addr_i != REG_ZERO)
                 && (int'(rd_addr_i) < NREG);
        data_d = fwd ? wb_val_i : src_val;
        busy_d = rd_en_i && src_pend && !fwd;
    end

    // Output flops load only when the port is enabled; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else if (rd_en_i) begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign rd_data_o = data_q;
    assign rd_busy_o = busy_q;
    assign busy_o    = busy_d;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with NRD registered read ports,
// write-to-read bypass and a per-register pending-write scoreboard.
module regfile_sb
    import rv32_pkg::*;
#(
    parameter int XLEN   = rv32_pkg::XLEN,
    parameter int NREG   = rv32_pkg::NREG,
    parameter int AW     = $clog2(NREG),
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic                hazard,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_reg,
    input  logic [XLEN-1:0]     wb_val,
    output logic [NREG-1:0]     pend
);

    logic [XLEN-1:0]          mem_q [1:NREG-1];
    logic [(NREG-1)*XLEN-1:0] mem_flat;
    logic [NREG-1:1]          pend_q, pend_d;
    logic [NRD-1:0]           busy_now;

    // Flatten storage so each read port can mux it.
    always_comb begin
        mem_flat = '0;
        for (int i = 1; i < NREG; i++) begin
            mem_flat[(i-1)*XLEN +: XLEN] = mem_q[i];
        end
    end

    // Writeback clears pending, then issue sets it so a new producer wins.
    always_comb begin
        pend_d = pend_q;
        for (int i = 1; i < NREG; i++) begin
            if (wb_en && int'(wb_reg) == i) begin
                pend_d[i] = 1'b0;
            end
            if (iss_en && int'(iss_rd) == i) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    // Storage: x0 is not stored, out-of-range writes match no entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wb_en) begin
            for (int i = 1; i < NREG; i++) begin
                if (int'(wb_reg) == i) begin
                    mem_q[i] <= wb_val;
                end
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_rdport #(
            .XLEN   (XLEN),
            .NREG   (NREG),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .rd_en_i   (rd_en[p]),
            .rd_addr_i (rd_addr[p*AW +: AW]),
            .wb_en_i   (wb_en),
            .wb_reg_i  (wb_reg),
            .wb_val_i  (wb_val),
            .mem_i     (mem_flat),
            .pend_i    (pend_q),
            .rd_data_o (rd_data[p*XLEN +: XLEN]),
            .rd_busy_o (rd_busy[p]),
            .busy_o    (busy_now[p])
        );
    end

    assign hazard = |busy_now;
    assign pend   = {pend_q, 1'b0};

endmodule
